// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master bus arbiter with hold limit and forced release (optional round-robin ties: BUS_ARB_RR_EN)
module bus_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m1_breq,
    input  logic       m2_breq,
    input  logic       bus_tx_active,
    output logic       m1_bgrant,
    output logic       m2_bgrant,
    output logic       msel,
    output logic [1:0] arb_state_show,
    output logic       preempt_pulse
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_M1 = 2'd1,
        GRANT_M2 = 2'd2,
        HANDOVER = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
    localparam bit               PREEMPT_EN = (MAX_HOLD != 0);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_next;
    logic             preempt_flag;
    logic             flag_next;
    logic             pulse_next;
    logic             msel_next;
    logic             holder_req;
    logic             other_req;
    logic             preempt_ok;
    logic             tie_pick_m2;
    logic             entering_grant;

`ifdef BUS_ARB_RR_EN
    // 0 = M1, 1 = M2; starts at M2 so the first tie after reset goes to M1
    logic last_owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= 1'b1;
        end else if (entering_grant) begin
            last_owner <= (next_state == GRANT_M2);
        end
    end

    assign tie_pick_m2 = ~last_owner;
`else
    assign tie_pick_m2 = 1'b0;
`endif

    function automatic state_t arbitrate(input logic req1, input logic req2, input logic pick_m2);
        state_t result;
        result = IDLE;
        if (req1 && req2) begin
            result = pick_m2 ? GRANT_M2 : GRANT_M1;
        end else if (req1) begin
            result = GRANT_M1;
        end else if (req2) begin
            result = GRANT_M2;
        end
        return result;
    endfunction

    always_comb begin
        next_state     = state;
        hold_cnt_next  = hold_cnt;
        flag_next      = preempt_flag;
        pulse_next     = 1'b0;
        msel_next      = msel;
        entering_grant = 1'b0;

        holder_req = (state == GRANT_M2) ? m2_breq : m1_breq;
        other_req  = (state == GRANT_M2) ? m1_breq : m2_breq;
        preempt_ok = PREEMPT_EN && (hold_cnt >= MAX_HOLD_C) && other_req && !bus_tx_active;

        case (state)
            IDLE: begin
                next_state = arbitrate(m1_breq, m2_breq, tie_pick_m2);
            end
            GRANT_M1, GRANT_M2: begin
                // A voluntary release takes precedence over a forced one
                if (!holder_req) begin
                    next_state = HANDOVER;
                end else if (preempt_ok) begin
                    next_state = HANDOVER;
                    flag_next  = 1'b1;
                    pulse_next = 1'b1;
                end else if (hold_cnt != {CNT_W{1'b1}}) begin
                    hold_cnt_next = hold_cnt + 1'b1;
                end
            end
            HANDOVER: begin
                flag_next = 1'b0;
                // msel still names the previous holder during the dead cycle
                if (preempt_flag && msel && m1_breq) begin
                    next_state = GRANT_M1;
                end else if (preempt_flag && !msel && m2_breq) begin
                    next_state = GRANT_M2;
                end else begin
                    next_state = arbitrate(m1_breq, m2_breq, tie_pick_m2);
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if ((next_state == GRANT_M1 || next_state == GRANT_M2) && next_state != state) begin
            entering_grant = 1'b1;
            hold_cnt_next  = {{(CNT_W-1){1'b0}}, 1'b1};
            msel_next      = (next_state == GRANT_M2);
        end else if (next_state == IDLE || next_state == HANDOVER) begin
            hold_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            preempt_flag  <= 1'b0;
            preempt_pulse <= 1'b0;
            msel          <= 1'b0;
            m1_bgrant     <= 1'b0;
            m2_bgrant     <= 1'b0;
        end else begin
            state         <= next_state;
            hold_cnt      <= hold_cnt_next;
            preempt_flag  <= flag_next;
            preempt_pulse <= pulse_next;
            msel          <= msel_next;
            m1_bgrant     <= (next_state == GRANT_M1);
            m2_bgrant     <= (next_state == GRANT_M2);
        end
    end

    assign arb_state_show = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - vector-table bench with expectation queue for bus_arbiter
module tb_bus_arbiter;

    logic       clk;
    logic       rst;
    logic       m1_breq;
    logic       m2_breq;
    logic       bus_tx_active;
    logic       m1_bgrant;
    logic       m2_bgrant;
    logic       msel;
    logic [1:0] arb_state_show;
    logic       preempt_pulse;

`ifdef BUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    bus_arbiter #(.MAX_HOLD(16), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .m1_breq        (m1_breq),
        .m2_breq        (m2_breq),
        .bus_tx_active  (bus_tx_active),
        .m1_bgrant      (m1_bgrant),
        .m2_bgrant      (m2_bgrant),
        .msel           (msel),
        .arb_state_show (arb_state_show),
        .preempt_pulse  (preempt_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         tid;
        logic       rst;
        logic       m1;
        logic       m2;
        logic       tx;
        logic       g1;
        logic       g2;
        logic       ms;
        logic [1:0] st;
        logic       p;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    task automatic add(input int tid, input logic r, input logic a, input logic b, input logic t,
                       input logic g1, input logic g2, input logic ms, input logic [1:0] st,
                       input logic p);
        vec_t v;
        v.tid = tid; v.rst = r; v.m1 = a; v.m2 = b; v.tx = t;
        v.g1 = g1; v.g2 = g2; v.ms = ms; v.st = st; v.p = p;
        vecs.push_back(v);
    endtask

    initial begin
        vec_t       v;
        vec_t       e;
        logic       w;
        logic [1:0] st_hold;
        logic [1:0] st_other;
        int         waited;

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; m1_breq = 1'b1; m2_breq = 1'b1; bus_tx_active = 1'b0;

        // 1: reset with both requesting, then release
        add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 1, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 2: lone M2 for five cycles
        for (int k = 0; k < 5; k++) add(2, 0, 0, 1, 0, 0, 1, 1, 2, 0);
        add(2, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        add(2, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // 3: tie after an M2 owner, then a second tie, then handover to the loser
        for (int k = 0; k < 4; k++) add(3, 0, 1, 1, 0, 1, 0, 0, 1, 0);
        add(3, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        add(3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        w        = RR;
        st_hold  = w ? 2'd2 : 2'd1;
        st_other = w ? 2'd1 : 2'd2;
        for (int k = 0; k < 2; k++) add(3, 0, 1, 1, 0, !w, w, w, st_hold, 0);
        add(3, 0, w, !w, 0, 0, 0, w, 3, 0);
        add(3, 0, w, !w, 0, w, !w, !w, st_other, 0);
        add(3, 0, 0, 0, 0, 0, 0, !w, 3, 0);
        add(3, 0, 0, 0, 0, 0, 0, !w, 0, 0);

        // 4: forced release after 16 granted cycles, M2 follows despite m1_breq
        for (int k = 1; k <= 16; k++) add(4, 0, 1, (k >= 3), 0, 1, 0, 0, 1, 0);
        add(4, 0, 1, 1, 0, 0, 0, 0, 3, 1);
        add(4, 0, 1, 1, 0, 0, 1, 1, 2, 0);
        add(4, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        add(4, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // 5: preemption held off by an active transfer, then reset mid-grant
        for (int k = 1; k <= 25; k++) add(5, 0, 1, (k >= 3), 1, 1, 0, 0, 1, 0);
        add(5, 0, 1, 1, 0, 0, 0, 0, 3, 1);
        add(5, 0, 1, 1, 0, 0, 1, 1, 2, 0);
        add(5, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(5, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 6: holder drops on the very cycle preemption would fire -> no pulse
        for (int k = 1; k <= 16; k++) add(6, 0, 1, 1, 0, 1, 0, 0, 1, 0);
        add(6, 0, 0, 1, 0, 0, 0, 0, 3, 0);
        add(6, 0, 0, 1, 0, 0, 1, 1, 2, 0);
        add(6, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        add(6, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // 7: one-cycle request still gets a grant; re-grant straight out of HANDOVER
        add(7, 0, 0, 1, 0, 0, 1, 1, 2, 0);
        add(7, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        add(7, 0, 0, 1, 0, 0, 1, 1, 2, 0);
        add(7, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        add(7, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            rst           = v.rst;
            m1_breq       = v.m1;
            m2_breq       = v.m2;
            bus_tx_active = v.tx;
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (m1_bgrant !== e.g1 || m2_bgrant !== e.g2 || msel !== e.ms ||
                arb_state_show !== e.st || preempt_pulse !== e.p) begin
                n_bad++;
                $display("FAIL test%0d step%0d: got g1=%b g2=%b msel=%b state=%0d pulse=%b, want g1=%b g2=%b msel=%b state=%0d pulse=%b",
                         e.tid, i, m1_bgrant, m2_bgrant, msel, arb_state_show, preempt_pulse,
                         e.g1, e.g2, e.ms, e.st, e.p);
            end
        end

        rst           = 1'b1;
        m1_breq       = 1'b1;
        m2_breq       = 1'b1;
        bus_tx_active = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (m1_bgrant !== 1'b0 || m2_bgrant !== 1'b0 || msel !== 1'b0 ||
            arb_state_show !== 2'd0 || preempt_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL reset state: g1=%b g2=%b msel=%b state=%0d pulse=%b",
                     m1_bgrant, m2_bgrant, msel, arb_state_show, preempt_pulse);
        end

        rst    = 1'b0;
        waited = 0;
        while (m1_bgrant !== 1'b1 && waited < 8) begin
            @(posedge clk);
            #1;
            waited++;
        end
        n_cmp++;
        if (m1_bgrant !== 1'b1 || waited != 1) begin
            n_bad++;
            $display("FAIL wait for m1_bgrant after reset: g1=%b after %0d cycles", m1_bgrant, waited);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
